// File: rtl/masked_share_gen.sv
// Boolean masking front-end: splits one byte into NSHARES shares using
// fresh LFSR randomness; XOR of all shares recombines to the input byte.
module masked_share_gen #(
  parameter int          NSHARES = 8,
  parameter int          W       = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 seed_load,
  input  logic [15:0]          seed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSHARES*W-1:0] out_shares,
  output logic                 busy
);

  localparam int CW = (NSHARES > 2) ? $clog2(NSHARES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSHARES - 2);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [15:0]            lfsr_nx;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           acc_q, acc_d;
  logic [W-1:0]           rnd;
  logic [NSHARES*W-1:0]   sh_q, sh_d;

  // Eight Galois steps per cycle; the fresh random share is the low byte.
  always_comb begin
    lfsr_nx = lfsr_q;
    for (int i = 0; i < 8; i++) begin
      if (lfsr_nx[0]) lfsr_nx = (lfsr_nx >> 1) ^ 16'hB400;
      else            lfsr_nx = lfsr_nx >> 1;
    end
    rnd = lfsr_nx[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (seed_load)
          lfsr_d = (seed == 16'h0) ? 16'hACE1 : seed;
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_d = lfsr_nx;
        acc_d  = acc_q ^ rnd;
        cnt_d  = cnt_q + 1'b1;
        for (int i = 0; i < NSHARES - 1; i++)
          if (cnt_q == CW'(i)) sh_d[i*W +: W] = rnd;
        if (cnt_q == LAST) begin
          sh_d[(NSHARES-1)*W +: W] = acc_q ^ rnd;
          cnt_d   = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign out_shares = sh_q;

endmodule
